// File: rtl/hacd_mc_axi_pkg.sv
// Shared AXI write/read master definitions for the HACD memory-controller bus.
// Holds AXI field constants, the write-master state enum and the burst
// legality check that the write and read masters both use.
package hacd_mc_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_32B   = 3'b101;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int unsigned BEAT_BYTES   = 32;
  localparam int unsigned BOUNDARY_4KB = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } wr_state_e;

  // Returns 1 when a burst is 32-byte aligned and stays inside one 4KB page.
  // Only the page offset matters, so callers pass addr[11:0].
  function automatic logic check_wr_burst(input logic [11:0] addr, input logic [7:0] len);
    int unsigned end_off;
    end_off = 32'(addr) + (32'(len) + 32'd1) * BEAT_BYTES;
    return (addr[4:0] == 5'd0) && (end_off <= BOUNDARY_4KB);
  endfunction

endpackage

// File: rtl/hacd_mc_axi_wr_master.sv
// Single-outstanding AXI4 write master for the HACD memory-controller write bus.
// Takes one burst request (address + len) and a beat stream, issues AW, then the
// W beats with WLAST, then optionally waits for B, and pulses done/done_err.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_*                       burst request (valid/ready, byte address, beats-1)
//   src_*                       upstream beat stream (valid/ready, data, strobes)
//   axi_aw*, axi_w*, axi_b*     AXI4 write address / data / response channels
//   done, done_err              one-cycle completion pulse and its error flag
module hacd_mc_axi_wr_master
  import hacd_mc_axi_pkg::*;
#(
  parameter int unsigned DATA_W        = 256,
  parameter int unsigned ADDR_W        = 64,
  parameter int unsigned ID_W          = 4,
  parameter int unsigned AXI_ID        = 0,
  parameter int unsigned USE_BRESP     = 1,
  parameter int unsigned BRESP_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [7:0]            req_len,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [DATA_W-1:0]     src_data,
  input  logic [DATA_W/8-1:0]   src_strb,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic [ID_W-1:0]       axi_awid,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_wlast,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic [1:0]            axi_bresp,
  output logic                  done,
  output logic                  done_err
);

  localparam int unsigned TCNT_W = (BRESP_TIMEOUT > 1) ? $clog2(BRESP_TIMEOUT) : 1;

  wr_state_e         state;
  logic [7:0]        beat_cnt;
  logic [TCNT_W-1:0] tcnt;
  logic              in_data;
  logic              w_hs;
  logic              timeout_hit;

  // W channel is a straight pass-through of the beat stream, gated to DATA
  // so early upstream beats are held off until AW has completed.
  assign in_data     = (state == ST_DATA);
  assign axi_wvalid  = in_data && src_valid;
  assign src_ready   = in_data && axi_wready;
  assign axi_wdata   = src_data;
  assign axi_wstrb   = src_strb;
  assign axi_wlast   = in_data && (beat_cnt == axi_awlen);
  assign w_hs        = axi_wvalid && axi_wready;

  assign axi_awsize  = SIZE_32B;
  assign axi_awburst = BURST_INCR;
  assign axi_awid    = ID_W'(AXI_ID);

  // Last permitted RESP cycle; a zero timeout never fires.
  assign timeout_hit = (BRESP_TIMEOUT != 0) && (32'(tcnt) == BRESP_TIMEOUT - 32'd1);

  // Burst sequencer; done is raised on entry to DONE so it is high for exactly that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_ready   <= 1'b0;
      axi_awvalid <= 1'b0;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
      axi_bready  <= 1'b0;
      beat_cnt    <= '0;
      tcnt        <= '0;
      done        <= 1'b0;
      done_err    <= 1'b0;
    end else begin
      done     <= 1'b0;
      done_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_ready && req_valid) begin
            req_ready  <= 1'b0;
            axi_awaddr <= req_addr;
            axi_awlen  <= req_len;
            beat_cnt   <= '0;
            tcnt       <= '0;
            if (check_wr_burst(req_addr[11:0], req_len)) begin
              state       <= ST_ADDR;
              axi_awvalid <= 1'b1;
            end else begin
              // Illegal burst: report error without touching the bus.
              state    <= ST_DONE;
              done     <= 1'b1;
              done_err <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (axi_awready) begin
            axi_awvalid <= 1'b0;
            state       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            if (axi_wlast) begin
              beat_cnt <= '0;
              if (USE_BRESP != 0) begin
                state      <= ST_RESP;
                axi_bready <= 1'b1;
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        ST_RESP: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            state      <= ST_DONE;
            done       <= 1'b1;
            done_err   <= (axi_bresp != RESP_OKAY);
          end else if (timeout_hit) begin
            axi_bready <= 1'b0;
            state      <= ST_DONE;
            done       <= 1'b1;
            done_err   <= 1'b1;
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hacd_mc_axi_wr_master.sv
// Self-checking bench for hacd_mc_axi_wr_master: a B-channel instance (16-cycle
// timeout) and a no-B instance, driven by a randomising slave/source model.
module tb_hacd_mc_axi_wr_master;

  localparam int unsigned DW = 256;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = 4;
  localparam int unsigned TB_ID = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance
  logic          req_valid = 1'b0, req_ready;
  logic [63:0]   req_addr = '0;
  logic [7:0]    req_len = '0;
  logic          src_valid = 1'b0, src_ready;
  logic [DW-1:0] src_data = '0;
  logic [SW-1:0] src_strb = '0;
  logic          awvalid, awready = 1'b1;
  logic [63:0]   awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic [IW-1:0] awid;
  logic          wvalid, wready = 1'b1, wlast;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          bvalid = 1'b0, bready;
  logic [1:0]    bresp = 2'b00;
  logic          done, done_err;

  // No-B instance
  logic          n_req_valid = 1'b0, n_req_ready;
  logic [63:0]   n_req_addr = '0;
  logic [7:0]    n_req_len = '0;
  logic          n_src_valid = 1'b0, n_src_ready;
  logic [DW-1:0] n_src_data = '0;
  logic [SW-1:0] n_src_strb = '1;
  logic          n_awvalid;
  logic [63:0]   n_awaddr;
  logic [7:0]    n_awlen;
  logic [2:0]    n_awsize;
  logic [1:0]    n_awburst;
  logic [IW-1:0] n_awid;
  logic          n_wvalid, n_wlast;
  logic [DW-1:0] n_wdata;
  logic [SW-1:0] n_wstrb;
  logic          n_bready, n_done, n_done_err;
  logic          n_awready = 1'b1, n_wready = 1'b1, n_bvalid = 1'b0;
  logic [1:0]    n_bresp = 2'b00;

  hacd_mc_axi_wr_master #(
    .DATA_W(DW), .ADDR_W(64), .ID_W(IW), .AXI_ID(TB_ID), .USE_BRESP(1), .BRESP_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_strb(src_strb),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awlen(awlen),
    .axi_awsize(awsize), .axi_awburst(awburst), .axi_awid(awid),
    .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
    .axi_wlast(wlast), .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
    .done(done), .done_err(done_err)
  );

  hacd_mc_axi_wr_master #(
    .DATA_W(DW), .ADDR_W(64), .ID_W(IW), .AXI_ID(0), .USE_BRESP(0), .BRESP_TIMEOUT(16)
  ) dut_nb (
    .clk(clk), .rst(rst),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_addr(n_req_addr), .req_len(n_req_len),
    .src_valid(n_src_valid), .src_ready(n_src_ready), .src_data(n_src_data), .src_strb(n_src_strb),
    .axi_awvalid(n_awvalid), .axi_awready(n_awready), .axi_awaddr(n_awaddr), .axi_awlen(n_awlen),
    .axi_awsize(n_awsize), .axi_awburst(n_awburst), .axi_awid(n_awid),
    .axi_wvalid(n_wvalid), .axi_wready(n_wready), .axi_wdata(n_wdata), .axi_wstrb(n_wstrb),
    .axi_wlast(n_wlast), .axi_bvalid(n_bvalid), .axi_bready(n_bready), .axi_bresp(n_bresp),
    .done(n_done), .done_err(n_done_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Slave / source configuration
  int          wr_mode = 0;     // 0 always ready, 1 toggle 1,0,1,0, 2 random
  bit          aw_rand = 1'b0;
  bit          src_gap = 1'b0;
  bit          b_en = 1'b1;
  int          b_delay = 0;
  logic [1:0]  b_resp = 2'b00;
  bit          tog = 1'b0;
  int          b_wait = 0;
  bit          pop_pend = 1'b0;
  logic [DW-1:0] sq_data[$];
  logic [SW-1:0] sq_strb[$];
  logic [DW-1:0] exp_d[$];
  logic [SW-1:0] exp_s[$];

  // Observations of the main instance
  logic [DW-1:0] mw_data[$];
  logic [SW-1:0] mw_strb[$];
  bit            mw_last[$];
  int cyc = 0, aw_cnt = 0, awv_cycles = 0, done_cnt = 0;
  int done_cyc = -1, wlast_cyc = -1, b_cyc = -1, mirror_bad = 0, early_bad = 0;
  bit in_burst = 1'b0;
  logic last_err = 1'b0;
  logic [63:0] cap_awaddr = '0;
  logic [7:0]  cap_awlen = '0;
  logic [2:0]  cap_awsize = '0;
  logic [1:0]  cap_awburst = '0;
  logic [IW-1:0] cap_awid = '0;

  // Observations of the no-B instance
  int n_left = 0, n_idx = 0, n_w_cnt = 0, n_wlast_cyc = -1, n_done_cnt = 0, n_done_cyc = -1;
  int n_bready_seen = 0, n_data_bad = 0, n_fields_bad = 0, n_aw_cnt = 0;
  logic n_cap_err = 1'b0;
  bit n_pop = 1'b0;

  // Drive inputs on the falling edge, then sample 1 ns later what the next rising edge will see.
  always @(negedge clk) begin
    cyc++;
    if (pop_pend && sq_data.size() > 0) begin
      sq_data.delete(0);
      sq_strb.delete(0);
    end
    pop_pend = 1'b0;
    if (n_pop && n_left > 0) begin
      n_left--;
      n_idx++;
    end
    n_pop = 1'b0;

    awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    tog = ~tog;
    case (wr_mode)
      0: wready = 1'b1;
      1: wready = tog;
      default: wready = 1'($urandom_range(0, 1));
    endcase
    if (sq_data.size() > 0 && (!src_gap || $urandom_range(0, 3) != 0)) begin
      src_valid = 1'b1;
      src_data  = sq_data[0];
      src_strb  = sq_strb[0];
    end else begin
      src_valid = 1'b0;
      src_data  = '0;
      src_strb  = '0;
    end
    if (bready && !rst) b_wait++;
    else b_wait = 0;
    bvalid = b_en && bready && (b_wait > b_delay);
    bresp  = b_resp;
    n_src_valid = (n_left > 0);
    n_src_data  = DW'(n_idx);

    #1;
    if (rst) begin
      in_burst = 1'b0;
    end else begin
      if (awvalid) awv_cycles++;
      if (in_burst && ((src_ready !== wready) || (wvalid !== src_valid))) mirror_bad++;
      if (!in_burst && (wvalid || src_ready)) early_bad++;
      if (awvalid && awready) begin
        aw_cnt++;
        in_burst    = 1'b1;
        cap_awaddr  = awaddr;
        cap_awlen   = awlen;
        cap_awsize  = awsize;
        cap_awburst = awburst;
        cap_awid    = awid;
      end
      if (wvalid && wready) begin
        mw_data.push_back(wdata);
        mw_strb.push_back(wstrb);
        mw_last.push_back(wlast);
        pop_pend = 1'b1;
        if (wlast) begin
          wlast_cyc = cyc;
          in_burst  = 1'b0;
        end
      end
      if (bvalid && bready) b_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        last_err = done_err;
      end
      if (n_awvalid && n_awready) begin
        n_aw_cnt++;
        if (n_awaddr !== 64'd0 || n_awlen !== 8'd7 || n_awsize !== 3'b101 ||
            n_awburst !== 2'b01 || n_awid !== 4'd0) n_fields_bad++;
      end
      if (n_src_valid && n_src_ready) begin
        n_w_cnt++;
        n_pop = 1'b1;
        if (n_wdata !== DW'(n_idx) || n_wstrb !== '1) n_data_bad++;
        if (n_wlast) n_wlast_cyc = cyc;
      end
      if (n_bready) n_bready_seen++;
      if (n_done) begin
        n_done_cnt++;
        n_done_cyc = cyc;
        n_cap_err  = n_done_err;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference rule: aligned to a beat and not crossing a 4KB page.
  function automatic bit model_legal(input logic [63:0] a, input logic [7:0] l);
    return ((a % 64'd32) == 64'd0) && ((a % 64'd4096) + (64'(l) + 64'd1) * 64'd32 <= 64'd4096);
  endfunction

  task automatic clear_cap();
    mw_data.delete(); mw_strb.delete(); mw_last.delete();
    exp_d.delete(); exp_s.delete();
    aw_cnt = 0; awv_cycles = 0; early_bad = 0; mirror_bad = 0;
    wlast_cyc = -1; b_cyc = -1; done_cyc = -1;
  endtask

  task automatic queue_beats(input int nbeats);
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    for (int i = 0; i < nbeats; i++) begin
      for (int k = 0; k < int'(DW / 32); k++) d[k*32 +: 32] = $urandom;
      s = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
      sq_data.push_back(d); sq_strb.push_back(s);
      exp_d.push_back(d);   exp_s.push_back(s);
    end
  endtask

  // Issue one request to the main instance and wait (bounded) for its done pulse.
  task automatic issue(input logic [63:0] a, input logic [7:0] l, input int nbeats,
                       output bit ok, output int dpulses);
    int st;
    clear_cap();
    queue_beats(nbeats);
    st = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 50 && !req_ready; i++) begin @(negedge clk); #2; end
    req_valid = 1'b1; req_addr = a; req_len = l;
    @(negedge clk); #2;
    req_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != st) begin ok = 1'b1; break; end
      @(negedge clk); #2;
    end
    repeat (3) @(negedge clk);
    #2;
    dpulses = done_cnt - st;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #2;
    n_cmp++;
    if ({awvalid, wvalid, wlast, bready, done, done_err, src_ready, req_ready} !== 8'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000000",
        {awvalid, wvalid, wlast, bready, done, done_err, src_ready, req_ready});
    end
    n_cmp++;
    if (awaddr !== 64'd0 || awlen !== 8'd0) begin
      n_err++; $display("FAIL reset_aw: got addr %h len %0d want 0/0", awaddr, awlen);
    end
    @(negedge clk); rst = 1'b0; #2;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_rdy_early: got %b want 0", req_ready); end
    @(negedge clk); #2;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_rdy_rise: got %b want 1", req_ready); end
  endtask

  task automatic test_single_beat();
    bit ok; int dp;
    wr_mode = 0; aw_rand = 0; src_gap = 0; b_en = 1; b_delay = 0; b_resp = 2'b00;
    issue(64'h1000, 8'd0, 1, ok, dp);
    n_cmp++;
    if (!ok || dp != 1) begin n_err++; $display("FAIL single_done: got ok %0d pulses %0d want 1/1", ok, dp); end
    n_cmp++;
    if (cap_awaddr !== 64'h1000 || cap_awlen !== 8'd0 || cap_awsize !== 3'b101 ||
        cap_awburst !== 2'b01 || cap_awid !== IW'(TB_ID) || aw_cnt != 1) begin
      n_err++; $display("FAIL single_aw: got cnt %0d addr %h len %0d size %b burst %b id %0d want 1 1000 0 101 01 %0d",
        aw_cnt, cap_awaddr, cap_awlen, cap_awsize, cap_awburst, cap_awid, TB_ID);
    end
    n_cmp++;
    if (mw_data.size() != 1 || mw_last[0] !== 1'b1 || mw_data[0] !== exp_d[0] || mw_strb[0] !== exp_s[0]) begin
      n_err++; $display("FAIL single_w: got %0d beats want 1 beat with wlast and matching data", mw_data.size());
    end
    n_cmp++;
    if (b_cyc != wlast_cyc + 1 || done_cyc != b_cyc + 1) begin
      n_err++; $display("FAIL single_timing: got wlast %0d b %0d done %0d want b=wlast+1 done=b+1",
        wlast_cyc, b_cyc, done_cyc);
    end
    n_cmp++;
    if (last_err !== 1'b0) begin n_err++; $display("FAIL single_err: got %b want 0", last_err); end
  endtask

  task automatic test_toggle_burst();
    bit ok; int dp; int bad;
    wr_mode = 1; b_delay = 2; b_resp = 2'b00;
    issue(64'h2000, 8'd3, 4, ok, dp);
    bad = 0;
    for (int i = 0; i < mw_data.size() && i < exp_d.size(); i++)
      if (mw_data[i] !== exp_d[i] || mw_strb[i] !== exp_s[i] || mw_last[i] !== (i == 3)) bad++;
    n_cmp++;
    if (!ok || dp != 1 || mw_data.size() != 4 || bad != 0) begin
      n_err++; $display("FAIL toggle_beats: got ok %0d pulses %0d beats %0d bad %0d want 1 1 4 0",
        ok, dp, mw_data.size(), bad);
    end
    n_cmp++;
    if (mirror_bad != 0 || early_bad != 0) begin
      n_err++; $display("FAIL toggle_ready: got mirror %0d early %0d want 0 0", mirror_bad, early_bad);
    end
    n_cmp++;
    if (last_err !== 1'b0) begin n_err++; $display("FAIL toggle_err: got %b want 0", last_err); end
    wr_mode = 0;
  endtask

  task automatic test_bad_requests();
    logic [63:0] ta [4];
    logic [7:0]  tl [4];
    bit ok, legal; int dp, nb, bad;
    ta = '{64'h0FE0, 64'h1004, 64'h1F00, 64'h7000};
    tl = '{8'd1, 8'd0, 8'd7, 8'd255};
    b_delay = 0; b_resp = 2'b00;
    for (int t = 0; t < 4; t++) begin
      legal = model_legal(ta[t], tl[t]);
      nb = legal ? int'(tl[t]) + 1 : 2;
      issue(ta[t], tl[t], nb, ok, dp);
      bad = 0;
      for (int i = 0; i < mw_data.size() && i < exp_d.size(); i++)
        if (mw_data[i] !== exp_d[i] || mw_last[i] !== (i == nb - 1)) bad++;
      n_cmp++;
      if (!ok || dp != 1 || last_err !== !legal) begin
        n_err++; $display("FAIL bad_done[%0d]: got ok %0d pulses %0d err %b want 1 1 %b", t, ok, dp, last_err, !legal);
      end
      n_cmp++;
      if ((legal && (aw_cnt != 1 || mw_data.size() != nb || bad != 0 || sq_data.size() != 0)) ||
          (!legal && (awv_cycles != 0 || mw_data.size() != 0 || sq_data.size() != 2 || early_bad != 0))) begin
        n_err++; $display("FAIL bad_traffic[%0d]: got aw %0d awv %0d beats %0d bad %0d left %0d legal %0d",
          t, aw_cnt, awv_cycles, mw_data.size(), bad, sq_data.size(), legal);
      end
      sq_data.delete(); sq_strb.delete();
    end
  endtask

  task automatic test_no_bresp();
    n_left = 8; n_idx = 0; n_w_cnt = 0; n_aw_cnt = 0; n_bready_seen = 0; n_data_bad = 0;
    for (int i = 0; i < 50 && !n_req_ready; i++) begin @(negedge clk); #2; end
    n_req_valid = 1'b1; n_req_addr = 64'd0; n_req_len = 8'd7;
    @(negedge clk); #2;
    n_req_valid = 1'b0;
    for (int i = 0; i < 200 && n_done_cnt == 0; i++) begin @(negedge clk); #2; end
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if (n_done_cnt != 1 || n_cap_err !== 1'b0) begin
      n_err++; $display("FAIL nob_done: got pulses %0d err %b want 1 0", n_done_cnt, n_cap_err);
    end
    n_cmp++;
    if (n_w_cnt != 8 || n_aw_cnt != 1 || n_data_bad != 0 || n_fields_bad != 0) begin
      n_err++; $display("FAIL nob_traffic: got beats %0d aw %0d bad %0d/%0d want 8 1 0 0",
        n_w_cnt, n_aw_cnt, n_data_bad, n_fields_bad);
    end
    n_cmp++;
    if (n_done_cyc != n_wlast_cyc + 1 || n_bready_seen != 0) begin
      n_err++; $display("FAIL nob_timing: got wlast %0d done %0d bready %0d want done=wlast+1 bready 0",
        n_wlast_cyc, n_done_cyc, n_bready_seen);
    end
  endtask

  task automatic test_timeout();
    bit ok; int dp;
    b_en = 0;
    issue(64'h3000, 8'd1, 2, ok, dp);
    n_cmp++;
    if (!ok || dp != 1 || last_err !== 1'b1) begin
      n_err++; $display("FAIL timeout_done: got ok %0d pulses %0d err %b want 1 1 1", ok, dp, last_err);
    end
    n_cmp++;
    if (done_cyc != wlast_cyc + 1 + 16) begin
      n_err++; $display("FAIL timeout_cycles: got %0d want %0d", done_cyc - wlast_cyc - 1, 16);
    end
    b_en = 1;
  endtask

  task automatic test_bresp_err();
    bit ok; int dp;
    for (int r = 1; r < 4; r++) begin
      b_resp = 2'(r); b_delay = r;
      issue(64'h6000 + 64'(r) * 64'h40, 8'd1, 2, ok, dp);
      n_cmp++;
      if (!ok || dp != 1 || last_err !== 1'b1 || mw_data.size() != 2) begin
        n_err++; $display("FAIL bresp_err[%0d]: got ok %0d pulses %0d err %b beats %0d want 1 1 1 2",
          r, ok, dp, last_err, mw_data.size());
      end
    end
    b_resp = 2'b00;
  endtask

  task automatic test_random();
    bit ok, legal; int dp, nb, bad;
    logic [63:0] a; logic [7:0] l; logic [11:0] off;
    wr_mode = 2; aw_rand = 1; src_gap = 1;
    for (int t = 0; t < 20; t++) begin
      off = ($urandom_range(0, 5) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 127) * 32);
      a = (64'($urandom) << 12) | 64'(off);
      l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      b_delay = $urandom_range(0, 6);
      b_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      legal = model_legal(a, l);
      nb = legal ? int'(l) + 1 : 0;
      issue(a, l, nb, ok, dp);
      bad = 0;
      for (int i = 0; i < mw_data.size() && i < exp_d.size(); i++)
        if (mw_data[i] !== exp_d[i] || mw_strb[i] !== exp_s[i] || mw_last[i] !== (i == nb - 1)) bad++;
      n_cmp++;
      if (!ok || dp != 1 || last_err !== (!legal || b_resp != 2'b00)) begin
        n_err++; $display("FAIL rand_done[%0d]: addr %h len %0d got ok %0d pulses %0d err %b want 1 1 %b",
          t, a, l, ok, dp, last_err, (!legal || b_resp != 2'b00));
      end
      n_cmp++;
      if (aw_cnt != int'(legal) || mw_data.size() != nb || bad != 0 || mirror_bad != 0 || early_bad != 0 ||
          (legal && (cap_awaddr !== a || cap_awlen !== l))) begin
        n_err++; $display("FAIL rand_traffic[%0d]: addr %h len %0d got aw %0d beats %0d bad %0d mirror %0d early %0d want aw %0d beats %0d",
          t, a, l, aw_cnt, mw_data.size(), bad, mirror_bad, early_bad, legal, nb);
      end
    end
    wr_mode = 0; aw_rand = 0; src_gap = 0; b_resp = 2'b00;
  endtask

  task automatic test_reset_mid_burst();
    bit ok; int dp, st, bad;
    clear_cap();
    queue_beats(4);
    st = done_cnt;
    for (int i = 0; i < 50 && !req_ready; i++) begin @(negedge clk); #2; end
    req_valid = 1'b1; req_addr = 64'h4000; req_len = 8'd3;
    @(negedge clk); #2;
    req_valid = 1'b0;
    for (int i = 0; i < 100 && mw_data.size() < 2; i++) begin @(negedge clk); #2; end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({awvalid, wvalid, bready, wlast} !== 4'b0 || mw_data.size() != 2) begin
      n_err++; $display("FAIL rstmid_drop: got aw/w/b/last %b beats %0d want 0000 2",
        {awvalid, wvalid, bready, wlast}, mw_data.size());
    end
    repeat (3) @(negedge clk);
    sq_data.delete(); sq_strb.delete();
    @(negedge clk); rst = 1'b0; #2;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_rdy_early: got %b want 0", req_ready); end
    @(negedge clk); #2;
    n_cmp++;
    if (req_ready !== 1'b1 || done_cnt != st) begin
      n_err++; $display("FAIL rstmid_rdy: got rdy %b pulses %0d want 1 0", req_ready, done_cnt - st);
    end
    b_delay = 1;
    issue(64'h5000, 8'd1, 2, ok, dp);
    bad = 0;
    for (int i = 0; i < mw_data.size() && i < exp_d.size(); i++)
      if (mw_data[i] !== exp_d[i] || mw_last[i] !== (i == 1)) bad++;
    n_cmp++;
    if (!ok || dp != 1 || last_err !== 1'b0 || mw_data.size() != 2 || bad != 0 || cap_awaddr !== 64'h5000) begin
      n_err++; $display("FAIL rstmid_fresh: got ok %0d pulses %0d err %b beats %0d bad %0d want 1 1 0 2 0",
        ok, dp, last_err, mw_data.size(), bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_toggle_burst();
    test_bad_requests();
    test_no_bresp();
    test_timeout();
    test_bresp_err();
    test_random();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hacd_mc_axi_wr_master.md
Name: hacd_mc_axi_wr_master

Overview:
- Upstream AXI4 write master feeding the memory-controller write bus (HACD_MC_AXI_WR_BUS master side).
- Accepts one burst request (line address + beat count) plus a beat data stream from the Hawk compaction/writeback logic.
- Issues AW, then W beats with WLAST, then optionally collects B.
- Reports completion or error per request; one outstanding burst only.

Parameters:
- DATA_W, 256: AXI data width; 32-byte beats.
- ADDR_W, 64: AXI address width.
- ID_W, 4: AWID width.
- AXI_ID, 0: constant AWID driven on every burst.
- USE_BRESP, 1: 1 = wait for the B handshake; 0 = complete on the last W handshake with bready held 0.
- BRESP_TIMEOUT, 1024: cycles allowed in RESP before a forced error completion; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  block idle and able to accept a request.
- req_addr  in  ADDR_W  byte address of the first beat.
- req_len  in  8  beats minus 1 (AXI len encoding).
- src_valid  in  1  data beat valid.
- src_ready  out  1  data beat accepted.
- src_data  in  DATA_W  beat data.
- src_strb  in  DATA_W/8  beat byte strobes.
- axi_awvalid / axi_awready  out / in  1 / 1  AW handshake.
- axi_awaddr  out  ADDR_W  burst start address.
- axi_awlen  out  8  burst length.
- axi_awsize  out  3  burst size.
- axi_awburst  out  2  burst type.
- axi_awid  out  ID_W  burst ID.
- axi_wvalid / axi_wready  out / in  1 / 1  W handshake.
- axi_wdata  out  DATA_W  write data.
- axi_wstrb  out  DATA_W/8  write strobes.
- axi_wlast  out  1  last beat of burst.
- axi_bvalid / axi_bready  in / out  1 / 1  B handshake.
- axi_bresp  in  2  write response.
- done  out  1  one-cycle completion pulse.
- done_err  out  1  error qualifier, valid only with done.

Behaviour:
- Reset (asynchronous, active-high, any state): state=IDLE; all of the following return to 0: axi_awvalid, axi_wvalid, axi_wlast, axi_bready, done, done_err, src_ready, req_ready, axi_awaddr, axi_awlen, beat counter, timeout counter.
  - req_ready rises the first cycle after rst deasserts.
  - Reset mid-burst abandons the burst; no done pulse is generated.
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, register addr and len.
  - If addr[4:0]!=0, or addr[11:0] + (len+1)*32 > 4096 (4KB crossing): go to DONE with error; no AXI traffic is issued.
  - Otherwise go to ADDR.
- ADDR:
  - axi_awvalid=1, registered and held stable until awready.
  - Constant fields: awsize=3'b101, awburst=2'b01 (INCR), awid=AXI_ID.
  - On awvalid&&awready: go to DATA. W never starts before AW completes.
- DATA:
  - Combinational pass-through: axi_wvalid=src_valid, src_ready=axi_wready, wdata/wstrb=src_data/src_strb.
  - axi_wlast=(beat_cnt==len_q).
  - beat_cnt increments on each W handshake.
  - On the handshake with wlast: go to RESP if USE_BRESP=1, else to DONE with success.
  - A beat with strb==0 is still transferred and counted.
- RESP:
  - axi_bready=1.
  - On bvalid: done_err=(bresp!=2'b00); go to DONE.
  - Timeout counter increments each cycle in RESP; reaching BRESP_TIMEOUT (when non-zero) goes to DONE with error.
- DONE: done=1 for exactly one cycle, then IDLE. req_ready=0 in every state except IDLE.
- Outside DATA: src_ready=0 and axi_wvalid=0; upstream data presented early is held off.
- Back-to-back requests: minimum 1 idle cycle (the DONE cycle) between bursts.
- beat_cnt is 8 bits; len=255 gives 256 beats with no wrap issue.

Decomposition:
- Package hacd_mc_axi_pkg holds:
  - AXI constants: BURST_INCR, SIZE_32B, RESP_OKAY.
  - The state enum typedef.
  - Beat-byte constant 32 and the 4KB boundary constant.
- No sub-module. The 4KB/alignment check is a package function, check_wr_burst(addr, len), reused by the read master.

Test Plan:
- Single beat: addr=0x1000, len=0, wready=1, bvalid the cycle after wlast, bresp=0.
  -> awaddr=0x1000, awlen=0, one W beat with wlast=1, done=1 with done_err=0 one cycle after the B handshake.
- 4-beat burst with wready toggled 1,0,1,0...
  -> exactly 4 W handshakes carrying data in order; wlast only on beat 4; src_ready mirrors wready.
- Bad requests:
  - addr=0x0FE0, len=1 (crosses 4KB) -> done=1, done_err=1, no awvalid ever asserted.
  - addr=0x1004 (misaligned) -> same: done=1, done_err=1, no awvalid ever asserted.
- USE_BRESP=0 against a slave with constant ready and no B channel, addr=0, len=7.
  -> done the cycle after the 8th beat; bready stays 0.
- BRESP_TIMEOUT=16, bvalid never asserted.
  -> done with done_err=1 exactly 16 cycles after entering RESP.
  - Separately, bresp=2'b10 -> done_err=1.
- rst asserted during DATA, after 2 of 4 beats.
  -> awvalid, wvalid, bready drop asynchronously; no done pulse; req_ready=1 one cycle after release; a fresh burst then completes cleanly.
